// File: rtl/dco_ctrl_pkg.sv
// Shared types and default sizing for the DCO frequency-lock controller.
// The controller walks an SAR search on alpha and then hands over to +/-1 tracking.
package dco_ctrl_pkg;

    localparam int DEF_ALPHA_W    = 3;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_SETTLE_CYC = 16;
    localparam int DEF_LOCK_N     = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        SAR_DECIDE,
        TRACK_DECIDE
    } state_t;

    typedef enum logic {
        SAR,
        TRACK
    } phase_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cbits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dco_edge_counter.sv
// Brings the free-running DCO output into the clk domain and counts its rising edges.
// The count output is the value the register will take at the next edge (this cycle included).
module dco_edge_counter
    import dco_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dco_clk,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic             s1, s2, s3;
    logic             rise;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= dco_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // Saturate rather than wrap so an overspeed DCO still reads as "too fast".
    always_comb begin
        count = cnt_q;
        if (clr)
            count = '0;
        else if (en && rise && (cnt_q != '1))
            count = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= count;
    end

endmodule

// File: rtl/dco_freq_ctrl.sv
// DCO frequency-lock controller: SAR search on alpha, then +/-1 tracking with lock detect.
// Larger alpha means more delay, hence fewer DCO edges per window.
module dco_freq_ctrl
    import dco_ctrl_pkg::*;
#(
    parameter int ALPHA_W    = DEF_ALPHA_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int LOCK_N     = DEF_LOCK_N
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               dco_clk,
    input  logic [CNT_W-1:0]   win_len,
    input  logic [CNT_W-1:0]   target_cnt,
    input  logic [CNT_W-1:0]   tol,
    output logic               dco_en,
    output logic [ALPHA_W-1:0] alpha,
    output logic [CNT_W-1:0]   meas_cnt,
    output logic               meas_valid,
    output logic               locked,
    output logic               sat,
    output logic               busy
);

    localparam int BIT_W = cbits(ALPHA_W);
    localparam int SET_W = cbits(SETTLE_CYC + 1);
    localparam int LCK_W = cbits(LOCK_N + 1);

    localparam logic [ALPHA_W-1:0] ALPHA_MAX = '1;
    localparam logic [ALPHA_W-1:0] ALPHA_MSB = ALPHA_W'(1) << (ALPHA_W - 1);

    state_t             state;
    phase_t             phase;
    logic [BIT_W-1:0]   bit_idx;
    logic [BIT_W-1:0]   bit_dn;
    logic [SET_W-1:0]   settle_cnt;
    logic [CNT_W-1:0]   win_cnt;
    logic [LCK_W-1:0]   lock_cnt;
    logic [LCK_W-1:0]   lock_inc;
    logic [CNT_W-1:0]   win_len_q, target_q, tol_q;
    logic [CNT_W-1:0]   win_len_in;
    logic [CNT_W-1:0]   edge_cnt;
    logic [ALPHA_W-1:0] sar_alpha;
    logic               settle_done, win_last;
    logic               too_fast, too_slow, blocked;
    logic signed [CNT_W:0] err, tol_s;

    dco_edge_counter #(.CNT_W(CNT_W)) u_edge_cnt (
        .clk     (clk),
        .rst     (rst),
        .dco_clk (dco_clk),
        .clr     (state != MEASURE),
        .en      (state == MEASURE),
        .count   (edge_cnt)
    );

    assign win_len_in  = (win_len == '0) ? CNT_W'(1) : win_len;
    assign settle_done = settle_cnt >= SET_W'(SETTLE_CYC);
    assign win_last    = win_cnt >= win_len_q;

    // One extra bit of signed headroom so count - target never wraps.
    assign err      = $signed({1'b0, meas_cnt}) - $signed({1'b0, target_q});
    assign tol_s    = $signed({1'b0, tol_q});
    assign too_fast = err > tol_s;
    assign too_slow = err < -tol_s;
    assign blocked  = (too_fast && (alpha == ALPHA_MAX)) || (too_slow && (alpha == '0));

    assign lock_inc = (lock_cnt >= LCK_W'(LOCK_N)) ? LCK_W'(LOCK_N) : lock_cnt + 1'b1;
    assign bit_dn   = bit_idx - 1'b1;

    // Resolve the current trial bit and stage the next lower one.
    always_comb begin
        sar_alpha = alpha;
        if (meas_cnt < target_q)
            sar_alpha[bit_idx] = 1'b0;
        if (bit_idx != '0)
            sar_alpha[bit_dn] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= SAR;
            bit_idx    <= '0;
            settle_cnt <= '0;
            win_cnt    <= '0;
            lock_cnt   <= '0;
            win_len_q  <= '0;
            target_q   <= '0;
            tol_q      <= '0;
            dco_en     <= 1'b0;
            alpha      <= '0;
            meas_cnt   <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            sat        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (stop) begin
                state  <= IDLE;
                dco_en <= 1'b0;
                locked <= 1'b0;
                sat    <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state      <= SETTLE;
                            phase      <= SAR;
                            alpha      <= ALPHA_MSB;
                            bit_idx    <= BIT_W'(ALPHA_W - 1);
                            settle_cnt <= SET_W'(1);
                            lock_cnt   <= '0;
                            locked     <= 1'b0;
                            sat        <= 1'b0;
                            dco_en     <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end

                    SETTLE: begin
                        if (settle_done) begin
                            state     <= MEASURE;
                            win_cnt   <= CNT_W'(1);
                            win_len_q <= win_len_in;
                            target_q  <= target_cnt;
                            tol_q     <= tol;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end

                    MEASURE: begin
                        if (win_last) begin
                            meas_cnt   <= edge_cnt;
                            meas_valid <= 1'b1;
                            state      <= (phase == SAR) ? SAR_DECIDE : TRACK_DECIDE;
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                        end
                    end

                    SAR_DECIDE: begin
                        alpha      <= sar_alpha;
                        settle_cnt <= SET_W'(1);
                        state      <= SETTLE;
                        if (bit_idx == '0) begin
                            phase    <= TRACK;
                            lock_cnt <= '0;
                        end else begin
                            bit_idx <= bit_dn;
                        end
                    end

                    TRACK_DECIDE: begin
                        if (too_fast || too_slow) begin
                            lock_cnt <= '0;
                            locked   <= 1'b0;
                            sat      <= blocked;
                        end else begin
                            lock_cnt <= lock_inc;
                            locked   <= (lock_inc == LCK_W'(LOCK_N));
                            sat      <= 1'b0;
                        end
                        if ((too_fast || too_slow) && !blocked) begin
                            alpha      <= too_fast ? alpha + 1'b1 : alpha - 1'b1;
                            settle_cnt <= SET_W'(1);
                            state      <= SETTLE;
                        end else begin
                            // No alpha step: reopen the window straight away.
                            state     <= MEASURE;
                            win_cnt   <= CNT_W'(1);
                            win_len_q <= win_len_in;
                            target_q  <= target_cnt;
                            tol_q     <= tol;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dco_freq_ctrl.sv
// Bench for dco_freq_ctrl: behavioural DCO with period (4+alpha) clk periods, vector table plus sequences.
module tb_dco_freq_ctrl;

    localparam int ALPHA_W = 3;
    localparam int CNT_W   = 16;
    localparam int WIN     = 1000;

    logic               clk = 1'b0;
    logic               rst, start, stop, dco_clk;
    logic [CNT_W-1:0]   win_len, target_cnt, tol;
    logic               dco_en, meas_valid, locked, sat, busy;
    logic [ALPHA_W-1:0] alpha;
    logic [CNT_W-1:0]   meas_cnt;

    int tests = 0;
    int fails = 0;
    int exp_q[$];
    bit mon_en   = 1'b0;
    bit drift    = 1'b0;
    bit mv_watch = 1'b0;
    int mv_seen  = 0;

    typedef struct {
        int target;
        int exp_alpha;
        int exp_locked;
        int exp_sat;
        int exp_cnt;
    } vec_t;
    vec_t vecs[3];

    dco_freq_ctrl #(
        .ALPHA_W(ALPHA_W), .CNT_W(CNT_W), .SETTLE_CYC(16), .LOCK_N(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dco_clk(dco_clk),
        .win_len(win_len), .target_cnt(target_cnt), .tol(tol),
        .dco_en(dco_en), .alpha(alpha), .meas_cnt(meas_cnt), .meas_valid(meas_valid),
        .locked(locked), .sat(sat), .busy(busy)
    );

    // clk period is 1000 time units; DCO edges are offset by 250 so they never meet a clk edge.
    always #500 clk = ~clk;

    always begin
        if (dco_en !== 1'b1) begin
            dco_clk = 1'b0;
            @(posedge dco_en);
            #250;
        end else begin
            #(((drift ? 5 : 4) + int'(alpha)) * 500) dco_clk = ~dco_clk;
        end
    end

    function automatic int model_cnt(input int a, input bit d);
        return WIN / ((d ? 5 : 4) + a);
    endfunction

    // Expected SAR walk; queues each trial window's count and returns the final alpha.
    function automatic int push_sar(input int tgt);
        int a = 0;
        int c;
        for (int b = ALPHA_W - 1; b >= 0; b--) begin
            a = a | (1 << b);
            c = model_cnt(a, 1'b0);
            exp_q.push_back(c);
            if (c < tgt) a = a & ~(1 << b);
        end
        return a;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_near(input string nm, input int act, input int exp, input int slack);
        tests++;
        if (act < exp - slack || act > exp + slack) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", nm, act, exp, slack);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && meas_valid && exp_q.size() > 0)
            chk_near("meas_cnt", int'(meas_cnt), exp_q.pop_front(), 1);
        if (mv_watch && meas_valid)
            mv_seen++;
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
    endtask

    task automatic wait_mv(input string nm, input int budget);
        int n = 0;
        @(negedge clk);
        while (meas_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (meas_valid !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL %s: no meas_valid within %0d cycles", nm, budget);
        end
    endtask

    task automatic wait_drain(input string nm, input int left, input int budget);
        int n = 0;
        while (exp_q.size() > left && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > left) begin
            tests++;
            fails++;
            $display("FAIL %s: %0d windows still pending after %0d cycles", nm, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_dco_en"},     int'(dco_en), 0);
        chk({nm, "_alpha"},      int'(alpha), 0);
        chk({nm, "_meas_cnt"},   int'(meas_cnt), 0);
        chk({nm, "_meas_valid"}, int'(meas_valid), 0);
        chk({nm, "_locked"},     int'(locked), 0);
        chk({nm, "_sat"},        int'(sat), 0);
        chk({nm, "_busy"},       int'(busy), 0);
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        vecs[0] = '{target: 300, exp_alpha: 0, exp_locked: 0, exp_sat: 1, exp_cnt: 250};
        vecs[1] = '{target: 50,  exp_alpha: 7, exp_locked: 0, exp_sat: 1, exp_cnt: 90};
        vecs[2] = '{target: 125, exp_alpha: 4, exp_locked: 1, exp_sat: 0, exp_cnt: 125};

        rst = 1'b1; start = 1'b0; stop = 1'b0;
        win_len = CNT_W'(WIN); target_cnt = 16'd125; tol = 16'd2;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Table: SAR search followed by five tracking windows per target.
        for (int i = 0; i < 3; i++) begin
            mon_en = 1'b0;
            exp_q.delete();
            target_cnt = CNT_W'(vecs[i].target);
            a = push_sar(vecs[i].target);
            for (int k = 0; k < 5; k++) exp_q.push_back(model_cnt(a, 1'b0));
            mon_en = 1'b1;
            pulse_start();
            chk("start_alpha_msb", int'(alpha), 4);
            chk("start_dco_en", int'(dco_en), 1);
            chk("start_busy", int'(busy), 1);
            wait_drain("vec_windows", 0, 12000);
            repeat (2) @(negedge clk);
            chk("vec_alpha", int'(alpha), vecs[i].exp_alpha);
            chk("vec_locked", int'(locked), vecs[i].exp_locked);
            chk("vec_sat", int'(sat), vecs[i].exp_sat);
            chk_near("vec_meas_cnt", int'(meas_cnt), vecs[i].exp_cnt, 1);
            if (i < 2) begin
                mon_en = 1'b0;
                pulse_stop();
                chk("stop_dco_en", int'(dco_en), 0);
                chk("stop_busy", int'(busy), 0);
                chk("stop_sat", int'(sat), 0);
                chk("stop_alpha_hold", int'(alpha), vecs[i].exp_alpha);
            end
        end

        // Drift while locked at 125: DCO slows, controller steps alpha to 3 and relocks.
        mon_en = 1'b0;
        exp_q.delete();
        wait_mv("drift_sync", 3000);
        @(negedge clk);
        drift = 1'b1;
        exp_q.push_back(model_cnt(4, 1'b1));
        for (int k = 0; k < 5; k++) exp_q.push_back(model_cnt(3, 1'b1));
        mon_en = 1'b1;
        wait_drain("drift_first", 5, 3000);
        repeat (2) @(negedge clk);
        chk("drift_unlock", int'(locked), 0);
        chk("drift_alpha", int'(alpha), 3);
        wait_drain("drift_relock", 0, 8000);
        repeat (2) @(negedge clk);
        chk("relock_locked", int'(locked), 1);
        chk("relock_alpha", int'(alpha), 3);
        chk("relock_sat", int'(sat), 0);

        // Stop in the middle of the second SAR window; start while busy is ignored.
        mon_en = 1'b0;
        exp_q.delete();
        drift = 1'b0;
        pulse_stop();
        target_cnt = 16'd125;
        pulse_start();
        wait_mv("stop_win1", 3000);
        repeat (200) @(negedge clk);
        chk("sar_trial2_alpha", int'(alpha), 6);
        pulse_start();
        chk("start_while_busy_alpha", int'(alpha), 6);
        chk("start_while_busy_busy", int'(busy), 1);
        pulse_stop();
        chk("midmeas_stop_dco_en", int'(dco_en), 0);
        chk("midmeas_stop_busy", int'(busy), 0);
        chk("midmeas_stop_alpha", int'(alpha), 6);
        repeat (20) @(negedge clk);
        chk("idle_alpha_hold", int'(alpha), 6);
        pulse_start();
        chk("restart_alpha", int'(alpha), 4);
        chk("restart_dco_en", int'(dco_en), 1);

        // Asynchronous reset while in SAR_DECIDE.
        wait_mv("rst_sync", 3000);
        #100 rst = 1'b1;
        #100;
        chk_reset_outputs("async_rst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mv_watch = 1'b1;
        repeat (2000) @(negedge clk);
        mv_watch = 1'b0;
        chk("post_rst_no_meas_valid", mv_seen, 0);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_dco_en", int'(dco_en), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dco_freq_ctrl.md
Name: dco_freq_ctrl

Overview:
- Frequency-locking controller that sits directly upstream of the DCO and drives the DCO enable (E) and delay select (alpha).
- Samples the DCO output, counts its rising edges over a programmable window of system clocks, and compares the count with a target.
- Coarse lock is found by successive approximation on alpha; ±1 tracking then holds lock.
- Increasing alpha adds delay and lowers the DCO frequency.

Parameters:
- ALPHA_W, 3, width of alpha (DCO tap select).
- CNT_W, 16, width of window length, target, tolerance and edge count.
- SETTLE_CYC, 16, clk cycles discarded after DCO enable or any alpha change.
- LOCK_N, 4, consecutive in-tolerance windows required to assert locked.

Ports:
- clk  in  1  system clock; must exceed 2.5x the DCO frequency.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level-sampled start request.
- stop  in  1  abort; has priority over start.
- dco_clk  in  1  DCO output, asynchronous to clk.
- win_len  in  CNT_W  measurement window in clk cycles; 0 is treated as 1.
- target_cnt  in  CNT_W  desired DCO edges per window.
- tol  in  CNT_W  allowed |count − target| in tracking.
- dco_en  out  1  DCO enable (E).
- alpha  out  ALPHA_W  DCO tap select.
- meas_cnt  out  CNT_W  last completed window count.
- meas_valid  out  1  one-cycle pulse when meas_cnt updates.
- locked  out  1  lock indicator.
- sat  out  1  alpha pinned at 0 or max while the error still points further.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: dco_en=0, alpha=0, meas_cnt=0, meas_valid=0, locked=0, sat=0, busy=0. All state, counters and synchronizer flops clear asynchronously, including mid-operation.
- Sampling: dco_clk passes through 3 flops (s1, s2, s3). A rising edge is s2 & ~s3. Edge count saturates at 2^CNT_W−1.
- Inputs win_len, target_cnt and tol are latched at the start of each window.
- IDLE: dco_en=0, alpha retained.
  - start=1 and stop=0 → SETTLE. On that transition alpha=2^(ALPHA_W−1) (MSB trial), bit index = MSB, dco_en=1.
- SETTLE: wait SETTLE_CYC cycles, then clear the counter → MEASURE.
- MEASURE: run win_len cycles.
  - On the last cycle, meas_cnt=count and meas_valid pulses on the next cycle.
  - Then → SAR_DECIDE or TRACK_DECIDE, depending on phase.
- SAR_DECIDE (one cycle):
  - Keep the current trial bit if count ≥ target, else clear it.
  - If bits remain, set the next lower bit → SETTLE.
  - After bit 0 is decided → SETTLE with phase=TRACK and lock counter=0.
- TRACK_DECIDE (one cycle), with err = count − target:
  - err > tol: alpha+1 (saturating).
  - err < −tol: alpha−1 (saturating).
  - Otherwise: alpha unchanged and lock counter +1 (saturating at LOCK_N).
  - An out-of-tolerance window clears the lock counter and deasserts locked in the same cycle.
  - locked asserts when the lock counter reaches LOCK_N.
  - sat=1 when the required step is blocked at a bound; otherwise sat=0.
  - → SETTLE if alpha changed, else → MEASURE.
- stop=1 in any state → IDLE next cycle: dco_en=0, locked=0, sat=0; alpha and meas_cnt hold.
- start while busy is ignored.
- Latency: first SAR decision at 1 + SETTLE_CYC + win_len + 1 cycles after start is accepted.
- Compare arithmetic uses CNT_W+1 signed width; no wrap-around.

Decomposition:
- Package dco_ctrl_pkg holds:
  - the state enum: IDLE, SETTLE, MEASURE, SAR_DECIDE, TRACK_DECIDE;
  - the phase enum: SAR, TRACK;
  - the default widths and constants.
- Sub-module dco_edge_counter: 3-flop synchronizer, edge detect, and saturating counter with clear/enable.

Test Plan:
- Bench model: clk period 1 ns; DCO period (4+alpha) ns; win_len=1000; tol=2; SETTLE_CYC=16; LOCK_N=4.
- Nominal lock, target 125: SAR trials give alpha 4 (125, keep), 6 (100, clear), 5 (111, clear) → alpha=4; locked after 4 tracking windows; meas_cnt=125, sat=0.
- Target 300 (unreachable, too slow): SAR ends at alpha=0 with count 250; tracking asserts sat=1, alpha stays 0, locked=0.
- Target 50 (too fast): SAR ends at alpha=7 with count 90; sat=1, alpha stays 7, locked=0.
- Drift while locked at target 125: model period becomes (5+alpha) ns, count 111 → locked drops, alpha steps to 3; count 125 → relocks after 4 windows.
- stop mid-MEASURE: dco_en=0 and busy=0 on the next cycle; alpha holds its value; a later start restarts SAR from alpha=4.
- rst pulsed during SAR_DECIDE: all outputs return to reset values immediately, with no meas_valid afterwards until a new start.
